systolic_ctrl: RTL and testbench

//  Sequencer for an N x N grid of pe cells (C = A x B, inner dimension k_len).

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_skew.sv | 32 +++
 rtl/systolic_ctrl.sv | 159 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer (systolic_ctrl).
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int N_DEF         = 4;
    localparam int K_MAX_DEF     = 16;
    localparam int DRAIN_CYC_DEF = 2 * N_DEF;

    localparam int IDX_W  = $clog2(K_MAX_DEF);
    localparam int KLEN_W = $clog2(K_MAX_DEF + 1);

endpackage

// File: rtl/systolic_skew.sv
// Combinational skew generator for one edge of the grid: lane g is fed
// during steps g .. g+k_len-1 with k-index t-g.
module systolic_skew #(
    parameter int N  = 4,
    parameter int IW = 4,
    parameter int KW = 5,
    parameter int TW = 5
) (
    input  logic [TW-1:0]   t_i,
    input  logic [KW-1:0]   k_len_i,
    input  logic            en_i,
    output logic [N-1:0]    vld_o,
    output logic [N*IW-1:0] idx_o
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [TW:0] t_ext;
        logic [TW:0] k_ext;
        logic [TW:0] rel;
        logic        hit;

        // One extra bit keeps t-g from wrapping into a false hit before lane start.
        assign t_ext = {1'b0, t_i};
        assign k_ext = (TW + 1)'(k_len_i);
        assign rel   = t_ext - (TW + 1)'(g);
        assign hit   = en_i && (t_ext >= (TW + 1)'(g)) && (rel < k_ext);

        assign vld_o[g]           = hit;
        assign idx_o[g*IW +: IW]  = hit ? rel[IW-1:0] : '0;
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic grid: clear, skewed operand feed, drain, done.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_cycles (busy cycles of last completed job).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int N         = N_DEF,
    parameter int K_MAX     = K_MAX_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          arr_clear,
    output logic [N-1:0]                  a_vld,
    output logic [N*$clog2(K_MAX)-1:0]    a_idx,
    output logic [N-1:0]                  b_vld,
    output logic [N*$clog2(K_MAX)-1:0]    b_idx,
    output logic                          res_capture
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int IW = $clog2(K_MAX);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int TW = $clog2(K_MAX + N);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    if (DATA_SIZE < 1 || N < 1 || K_MAX < 2 || DRAIN_CYC < 1) begin : g_bad_cfg
        $error("systolic_ctrl: unsupported parameter combination");
    end

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            abort_hit;
    logic [TW-1:0]   feed_last;
    logic            feed_en_d;
    logic [N-1:0]    a_vld_d, b_vld_d;
    logic [N*IW-1:0] a_idx_d, b_idx_d;

    // Modular add: N-2 may be -1 for a 1x1 grid, klen_q >= 1 whenever FEED is live.
    assign feed_last = TW'(klen_q) + TW'(N - 2);
    assign feed_en_d = (state_d == S_FEED);

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        klen_d    = klen_q;
        drain_d   = drain_q;
        abort_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    klen_d  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                    t_d     = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = (klen_q == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                if (t_q == feed_last) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYC - 1)) state_d = S_DONE;
                else                               drain_d = drain_q + DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && abort) begin
            abort_hit = 1'b1;
            state_d   = S_IDLE;
        end
    end

    systolic_skew #(.N(N), .IW(IW), .KW(KW), .TW(TW)) u_row_skew (
        .t_i     (t_d),
        .k_len_i (klen_d),
        .en_i    (feed_en_d),
        .vld_o   (a_vld_d),
        .idx_o   (a_idx_d)
    );

    systolic_skew #(.N(N), .IW(IW), .KW(KW), .TW(TW)) u_col_skew (
        .t_i     (t_d),
        .k_len_i (klen_d),
        .en_i    (feed_en_d),
        .vld_o   (b_vld_d),
        .idx_o   (b_idx_d)
    );

    // Outputs are registered from next-state so each one lines up with its state cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            klen_q      <= '0;
            drain_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            arr_clear   <= 1'b0;
            res_capture <= 1'b0;
            a_vld       <= '0;
            a_idx       <= '0;
            b_vld       <= '0;
            b_idx       <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            klen_q      <= klen_d;
            drain_q     <= drain_d;
            busy        <= (state_d != S_IDLE);
            done        <= (state_d == S_DONE);
            arr_clear   <= (state_d == S_CLEAR) || abort_hit;
            res_capture <= (state_d == S_DRAIN) && (drain_d == DW'(DRAIN_CYC - 1));
            a_vld       <= a_vld_d;
            a_idx       <= a_idx_d;
            b_vld       <= b_vld_d;
            b_idx       <= b_idx_d;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (state_d == S_IDLE)      busy_cnt_q <= '0;
            else if (busy_cnt_q != '1)  busy_cnt_q <= busy_cnt_q + 32'd1;
            // Aborted jobs never reach DONE, so the last completed count is held.
            if (state_d == S_DONE)
                perf_q <= (busy_cnt_q == '1) ? '1 : busy_cnt_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle expected output words are
// derived from the job timing formulas and compared at every falling edge.
module tb_systolic_ctrl;

    localparam int N         = 4;
    localparam int K_MAX     = 16;
    localparam int DRAIN_CYC = 8;
    localparam int IW        = 4;
    localparam int KW        = 5;
    localparam int W         = 4 + 2 * N + 2 * N * IW;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            abort;
    logic            busy;
    logic            done;
    logic            arr_clear;
    logic [N-1:0]    a_vld;
    logic [N*IW-1:0] a_idx;
    logic [N-1:0]    b_vld;
    logic [N*IW-1:0] b_idx;
    logic            res_capture;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    logic [W-1:0] exp_q[$];
    logic         mon_en;
    int           n_chk;
    int           n_err;

    systolic_ctrl #(.DATA_SIZE(8), .N(N), .K_MAX(K_MAX), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .k_len       (k_len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .arr_clear   (arr_clear),
        .a_vld       (a_vld),
        .a_idx       (a_idx),
        .b_vld       (b_vld),
        .b_idx       (b_idx),
        .res_capture (res_capture)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] dut_word();
        return {busy, done, arr_clear, res_capture, a_vld, b_vld, a_idx, b_idx};
    endfunction

    // Expected outputs in cycle c after a start accepted at cycle 0 (k already clamped).
    function automatic logic [W-1:0] exp_word(input int k, input int c);
        logic            b, d, cl, cp;
        logic [N-1:0]    av;
        logic [N*IW-1:0] ai;
        int              done_c;
        int              t;
        b = 1'b0; d = 1'b0; cl = 1'b0; cp = 1'b0; av = '0; ai = '0;
        done_c = (k == 0) ? 2 : k + N + 1 + DRAIN_CYC;
        if (c >= 1 && c <= done_c) b = 1'b1;
        if (c == 1) cl = 1'b1;
        if (c == done_c) d = 1'b1;
        if (k > 0 && c == done_c - 1) cp = 1'b1;
        if (k > 0 && c >= 2 && c <= k + N) begin
            t = c - 2;
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < i + k) begin
                    av[i] = 1'b1;
                    ai[i*IW +: IW] = IW'(t - i);
                end
            end
        end
        return {b, d, cl, cp, av, av, ai, ai};
    endfunction

    function automatic logic [W-1:0] abort_word();
        logic [W-1:0] w;
        w = '0;
        w[W-3] = 1'b1;
        return w;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: one expected word per cycle while a job is in flight, idle otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) check("cycle", dut_word(), exp_q.pop_front());
            else                  check("idle", dut_word(), '0);
        end
    end

    // driver: called at #1 after a rising edge in an IDLE cycle (that cycle is cycle 0)
    task automatic run_job(input int k_in, input int abort_c, input bit keep_start,
                           input bit abort_with_start);
        int k;
        int done_c;
        int last_walk;
        k         = (k_in > K_MAX) ? K_MAX : k_in;
        done_c    = (k == 0) ? 2 : k + N + 1 + DRAIN_CYC;
        last_walk = (abort_c > 0) ? abort_c : done_c;
        start = 1'b1;
        k_len = KW'(k_in);
        abort = abort_with_start;
        @(posedge clk); #1;
        start = keep_start;
        abort = 1'b0;
        for (int c = 1; c <= last_walk; c++) exp_q.push_back(exp_word(k, c));
        if (abort_c > 0) exp_q.push_back(abort_word());
        for (int c = 1; c <= last_walk; c++) begin
            abort = (c == abort_c);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        k_len   = '0;
        abort   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_word(), '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // asynchronous reset in the middle of FEED (k_len=4, t=2)
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4 + N + 1 + DRAIN_CYC; c++) exp_q.push_back(exp_word(4, c));
        idle_cycles(3);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset", dut_word(), '0);
        exp_q.delete();
        @(posedge clk); #1;
        check("reset_hold", dut_word(), '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_job(4, 0, 1'b0, 1'b0);
        idle_cycles(2);

        // nominal, zero-length, random-length jobs
        run_job(3, 0, 1'b0, 1'b0);
        idle_cycles(1);
        run_job(0, 0, 1'b0, 1'b0);
        idle_cycles(1);
        run_job($urandom_range(1, K_MAX), 0, 1'b0, 1'b0);
        idle_cycles($urandom_range(1, 3));

        // abort in FEED at t=2, then start in the very next (IDLE) cycle
        run_job(5, 4, 1'b0, 1'b0);
        run_job(2, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // abort during DRAIN suppresses res_capture and done
        run_job(2, 10, 1'b0, 1'b0);
        idle_cycles(2);

        // start held through a job: ignored while busy, back-to-back after done
        run_job(2, 0, 1'b1, 1'b0);
        run_job(1, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // k_len above K_MAX is clamped
        run_job(31, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // abort in IDLE has no effect; abort with start in IDLE lets start win
        abort = 1'b1;
        idle_cycles(2);
        abort = 1'b0;
        run_job(3, 0, 1'b0, 1'b1);
        idle_cycles(3);

        check("queue_empty", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
